// File: rtl/or1200_keccak_if_pkg.sv
// ----------------------------------------------------------------------------
// or1200_keccak_if_pkg
//   Shared definitions for the l.cust5 Keccak adapter:
//     - cust5 op codes (INIT/START/MIDDLE/END/STORE)
//     - adapter FSM state encoding
//     - lane_t: one FIFO entry {last, words, data}, 66 bits
//     - make_lane(): builds a lane_t from two 32-bit halves and flags
// ----------------------------------------------------------------------------
package or1200_keccak_if_pkg;

    localparam logic [4:0] OP_INIT   = 5'b00000;
    localparam logic [4:0] OP_START  = 5'b00100;
    localparam logic [4:0] OP_MIDDLE = 5'b00010;
    localparam logic [4:0] OP_END    = 5'b00001;
    localparam logic [4:0] OP_STORE  = 5'b01000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ABSORB,
        ST_FLUSH,
        ST_WAIT_DIG,
        ST_DONE
    } state_t;

    // words: 0 = both halves valid, 1 = only data[31:0] valid (data[63:32] zero)
    typedef struct packed {
        logic        last;
        logic        words;
        logic [63:0] data;
    } lane_t;

    function automatic lane_t make_lane(input logic [31:0] hi,
                                        input logic [31:0] lo,
                                        input logic        one_word,
                                        input logic        is_last);
        lane_t l;
        l.last  = is_last;
        l.words = one_word;
        l.data  = {hi, lo};
        return l;
    endfunction

endpackage

// File: rtl/or1200_keccak_lane_fifo.sv
// ----------------------------------------------------------------------------
// or1200_keccak_lane_fifo
//   Small synchronous FIFO holding lanes on their way to the Keccak core.
//   DEPTH must be a power of two so the pointers wrap by plain overflow.
//   Ports:
//     clk, rst     clock, asynchronous active-low reset
//     clr          drop all contents (INIT/START); wins over pop
//     push         write push_lane (caller guarantees !full or pop this cycle)
//     push_lane    lane to enqueue
//     pop          advance the head (caller guarantees !empty)
//     head_lane    current head; all-zero while empty
//     full, empty  occupancy flags
// ----------------------------------------------------------------------------
module or1200_keccak_lane_fifo
    import or1200_keccak_if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  push,
    input  lane_t push_lane,
    input  logic  pop,
    output lane_t head_lane,
    output logic  full,
    output logic  empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    lane_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    // One bit wider than the pointers so full and empty are distinguishable.
    logic [PTR_W:0]   count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; only pointers and count do, and the
    // head is forced to zero while empty, so stale contents never reach a port.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_lane;
        end
    end

    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign head_lane = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/or1200_keccak_if.sv
// ----------------------------------------------------------------------------
// or1200_keccak_if
//   Execute-stage adapter between the l.cust5 decode in or1200_ctrl and an
//   external Keccak-f core. START/MIDDLE/END ops absorb 32-bit rA operands,
//   which are paired into 64-bit lanes and streamed through a ready/valid FIFO.
//   Once the core returns the 512-bit digest, STORE ops read it back one
//   32-bit word at a time towards the rf_dataw mux.
//   Ports:
//     clk, rst                        clock, asynchronous active-low reset
//     cust5_valid/op/limm, opa        op strobe, op code, STORE index, rA value
//     busy                            combinational stall request to freeze
//     result, result_valid            registered STORE read data (latency 1)
//     err                             sticky protocol error, cleared by INIT/START
//     core_init                       registered one-cycle core clear pulse
//     lane_data/words/last/valid      lane stream to the core
//     lane_ready                      core accepts the current lane
//     digest, digest_valid            digest from the core, one-cycle strobe
// ----------------------------------------------------------------------------
module or1200_keccak_if
    import or1200_keccak_if_pkg::*;
#(
    parameter int LANE_FIFO_DEPTH = 2,
    parameter int DIGEST_WORDS    = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cust5_valid,
    input  logic [4:0]   cust5_op,
    input  logic [5:0]   cust5_limm,
    input  logic [31:0]  opa,
    output logic         busy,
    output logic [31:0]  result,
    output logic         result_valid,
    output logic         err,
    output logic         core_init,
    output logic [63:0]  lane_data,
    output logic         lane_words,
    output logic         lane_last,
    output logic         lane_valid,
    input  logic         lane_ready,
    input  logic [511:0] digest,
    input  logic         digest_valid
);

    state_t      state;
    logic [31:0] hold_q;
    logic        hold_full;
    logic [31:0] digest_q [DIGEST_WORDS];

    logic op_init;
    logic op_start;
    logic op_mid;
    logic op_end;
    logic op_store;

    lane_t push_lane;
    lane_t head_lane;
    logic  fifo_clr;
    logic  fifo_push;
    logic  fifo_pop;
    logic  fifo_full;
    logic  fifo_empty;
    logic  fifo_room;
    logic  push_req;

    logic [3:0] store_idx;
    logic       unused_limm_hi;

    // ------------------------------------------------------------------
    // Op decode. ctrl already qualifies cust5_valid with !ex_freeze.
    // ------------------------------------------------------------------
    assign op_init  = cust5_valid && (cust5_op == OP_INIT);
    assign op_start = cust5_valid && (cust5_op == OP_START);
    assign op_mid   = cust5_valid && (cust5_op == OP_MIDDLE);
    assign op_end   = cust5_valid && (cust5_op == OP_END);
    assign op_store = cust5_valid && (cust5_op == OP_STORE);

    // The word index wraps modulo 16; the upper limm bits carry no meaning.
    assign store_idx      = cust5_limm[3:0];
    assign unused_limm_hi = ^cust5_limm[5:4];

    // ------------------------------------------------------------------
    // Lane assembly. END always emits exactly one lane: either it pairs
    // with the held word, or it goes out alone as a one-word lane.
    // ------------------------------------------------------------------
    assign push_req  = (state == ST_ABSORB) && (op_end || (op_mid && hold_full));
    assign push_lane = (op_end && !hold_full) ? make_lane(32'h0, opa, 1'b1, 1'b1)
                                              : make_lane(opa, hold_q, 1'b0, op_end);

    // A pop in the same cycle frees the entry the push needs.
    assign fifo_pop  = lane_valid && lane_ready;
    assign fifo_room = !fifo_full || fifo_pop;
    assign fifo_push = push_req && fifo_room;
    assign fifo_clr  = op_init || op_start;

    // Stall: a lane push with no free entry, or a STORE before the digest.
    assign busy = (push_req && !fifo_room) ||
                  (op_store && ((state == ST_FLUSH) || (state == ST_WAIT_DIG)));

    or1200_keccak_lane_fifo #(
        .DEPTH (LANE_FIFO_DEPTH)
    ) u_lane_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (fifo_clr),
        .push      (fifo_push),
        .push_lane (push_lane),
        .pop       (fifo_pop),
        .head_lane (head_lane),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign lane_valid = !fifo_empty;
    assign lane_data  = head_lane.data;
    assign lane_words = head_lane.words;
    assign lane_last  = head_lane.last;

    // ------------------------------------------------------------------
    // FSM, holding register, digest register and registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            hold_q       <= '0;
            hold_full    <= 1'b0;
            err          <= 1'b0;
            core_init    <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            for (int i = 0; i < DIGEST_WORDS; i++) begin
                digest_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking pulse defaults first; any later assignment in
            // this block overrides them for the current cycle.
            core_init    <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;

            if (op_init || op_start) begin
                // INIT and START share the clear; START then seeds the holding
                // register. A digest arriving this cycle is dropped.
                core_init <= 1'b1;
                err       <= 1'b0;
                hold_q    <= op_start ? opa : 32'h0;
                hold_full <= op_start;
                state     <= op_start ? ST_ABSORB : ST_IDLE;
            end else begin
                case (state)
                    ST_ABSORB: begin
                        if (op_mid && !hold_full) begin
                            hold_q    <= opa;
                            hold_full <= 1'b1;
                        end else if (fifo_push) begin
                            hold_full <= 1'b0;
                            if (op_end) begin
                                state <= ST_FLUSH;
                            end
                        end
                    end
                    ST_FLUSH: begin
                        // The last lane is the final entry, so an empty FIFO
                        // means it has handshaken.
                        if (fifo_empty) begin
                            state <= ST_WAIT_DIG;
                        end
                    end
                    ST_WAIT_DIG: begin
                        if (digest_valid) begin
                            for (int i = 0; i < DIGEST_WORDS; i++) begin
                                digest_q[i] <= digest[32*i +: 32];
                            end
                            state <= ST_DONE;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase

                if ((op_mid || op_end) && (state != ST_ABSORB)) begin
                    err <= 1'b1;
                end

                // STORE in FLUSH/WAIT_DIG is held off by busy and never gets here.
                if (op_store) begin
                    if (state == ST_DONE) begin
                        result       <= digest_q[store_idx];
                        result_valid <= 1'b1;
                    end else if ((state == ST_IDLE) || (state == ST_ABSORB)) begin
                        result_valid <= 1'b1;
                        err          <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_or1200_keccak_if.sv
// ----------------------------------------------------------------------------
// tb_or1200_keccak_if
//   Self-checking bench for or1200_keccak_if. A transaction-level model
//   (lane queue, held word, phase, digest array) predicts every output each
//   cycle; directed sequences add literal expectations on top.
// ----------------------------------------------------------------------------
module tb_or1200_keccak_if;

    localparam int DEPTH = 2;

    localparam bit [4:0] K_INIT  = 5'b00000;
    localparam bit [4:0] K_START = 5'b00100;
    localparam bit [4:0] K_MID   = 5'b00010;
    localparam bit [4:0] K_END   = 5'b00001;
    localparam bit [4:0] K_STORE = 5'b01000;

    typedef enum {P_IDLE, P_ABSORB, P_FLUSH, P_WAIT, P_DONE} phase_e;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cust5_valid = 1'b0;
    logic [4:0]   cust5_op = '0;
    logic [5:0]   cust5_limm = '0;
    logic [31:0]  opa = '0;
    logic         busy;
    logic [31:0]  result;
    logic         result_valid;
    logic         err;
    logic         core_init;
    logic [63:0]  lane_data;
    logic         lane_words;
    logic         lane_last;
    logic         lane_valid;
    logic         lane_ready = 1'b0;
    logic [511:0] digest = '0;
    logic         digest_valid = 1'b0;

    or1200_keccak_if #(
        .LANE_FIFO_DEPTH (DEPTH),
        .DIGEST_WORDS    (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cust5_valid  (cust5_valid),
        .cust5_op     (cust5_op),
        .cust5_limm   (cust5_limm),
        .opa          (opa),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .err          (err),
        .core_init    (core_init),
        .lane_data    (lane_data),
        .lane_words   (lane_words),
        .lane_last    (lane_last),
        .lane_valid   (lane_valid),
        .lane_ready   (lane_ready),
        .digest       (digest),
        .digest_valid (digest_valid)
    );

    always #5 clk = ~clk;

    // Model state
    phase_e    m_phase;
    bit        m_hold_v;
    bit [31:0] m_hold;
    bit [65:0] m_q [$];
    bit [31:0] m_dig [16];
    bit        m_err, m_ci, m_rv;
    bit [31:0] m_res;

    // Bench bookkeeping
    int        total = 0;
    int        bad = 0;
    int        cyc = 0;
    bit [65:0] lane_log [$];
    int        stall_until = 0;
    int        dig_at = -1;
    bit        rand_ready = 1'b0;
    bit        rand_dig = 1'b0;
    bit [511:0] dig_fixed = '0;
    int        first_busy_opa = -1;
    bit [31:0] s_result;
    bit        s_rv, s_err, s_ci, s_lv;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_phase  = P_IDLE;
        m_hold_v = 1'b0;
        m_hold   = '0;
        m_q.delete();
        for (int i = 0; i < 16; i++) m_dig[i] = '0;
        m_err = 1'b0;
        m_ci  = 1'b0;
        m_rv  = 1'b0;
        m_res = '0;
    endfunction

    function automatic void set_pattern(input bit [31:0] base);
        for (int i = 0; i < 16; i++) dig_fixed[32*i +: 32] = base + 32'(i);
    endfunction

    function automatic bit [65:0] log_at(input int i);
        if (i < lane_log.size()) return lane_log[i];
        return '0;
    endfunction

    // One clock cycle: drive inputs, compare every output with the model,
    // then advance the model by the effect of the coming rising edge.
    task automatic cycle(input bit v, input bit [4:0] op, input bit [5:0] limm,
                         input bit [31:0] a, output bit acc);
        bit        rdy, dv, lv, pop, is_m, is_e, is_s, wants_push, room, busy_e, was_empty;
        bit [65:0] head;
        bit [511:0] dg;
        phase_e    ph;
        @(negedge clk);
        cyc++;
        rdy = (cyc < stall_until) ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        if (rand_dig) begin
            dv = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < 16; i++) dg[32*i +: 32] = $urandom();
        end else begin
            dv = (cyc == dig_at);
            dg = dig_fixed;
        end
        cust5_valid  = v;
        cust5_op     = op;
        cust5_limm   = limm;
        opa          = a;
        lane_ready   = rdy;
        digest_valid = dv;
        digest       = dg;
        #1;
        ph   = m_phase;
        lv   = (m_q.size() != 0);
        head = lv ? m_q[0] : '0;
        pop  = lv && rdy;
        is_m = v && (op == K_MID);
        is_e = v && (op == K_END);
        is_s = v && (op == K_STORE);
        wants_push = (ph == P_ABSORB) && (is_e || (is_m && m_hold_v));
        room   = (m_q.size() < DEPTH) || pop;
        busy_e = (wants_push && !room) || (is_s && (ph == P_FLUSH || ph == P_WAIT));
        acc    = v && !busy_e;

        check("busy", busy, busy_e);
        check("lane_valid", lane_valid, lv);
        check("lane", {lane_last, lane_words, lane_data}, head);
        check("result", result, m_res);
        check("result_valid", result_valid, m_rv);
        check("err", err, m_err);
        check("core_init", core_init, m_ci);

        if (lane_valid && lane_ready) lane_log.push_back({lane_last, lane_words, lane_data});
        s_result = result;
        s_rv     = result_valid;
        s_err    = err;
        s_ci     = core_init;
        s_lv     = lane_valid;

        was_empty = (m_q.size() == 0);
        m_ci  = 1'b0;
        m_rv  = 1'b0;
        m_res = '0;
        if (pop) void'(m_q.pop_front());
        if (acc && (op == K_INIT || op == K_START)) begin
            m_q.delete();
            m_ci     = 1'b1;
            m_err    = 1'b0;
            m_hold_v = (op == K_START);
            m_hold   = (op == K_START) ? a : 32'h0;
            m_phase  = (op == K_START) ? P_ABSORB : P_IDLE;
        end else begin
            if (ph == P_FLUSH && was_empty) m_phase = P_WAIT;
            if (ph == P_WAIT && dv) begin
                for (int i = 0; i < 16; i++) m_dig[i] = dg[32*i +: 32];
                m_phase = P_DONE;
            end
            if (acc && (op == K_MID || op == K_END)) begin
                if (ph != P_ABSORB) begin
                    m_err = 1'b1;
                end else if (op == K_END) begin
                    if (m_hold_v) m_q.push_back({1'b1, 1'b0, a, m_hold});
                    else          m_q.push_back({1'b1, 1'b1, 32'h0, a});
                    m_hold_v = 1'b0;
                    m_phase  = P_FLUSH;
                end else if (m_hold_v) begin
                    m_q.push_back({1'b0, 1'b0, a, m_hold});
                    m_hold_v = 1'b0;
                end else begin
                    m_hold   = a;
                    m_hold_v = 1'b1;
                end
            end else if (acc && op == K_STORE) begin
                m_rv = 1'b1;
                if (ph == P_DONE) m_res = m_dig[limm[3:0]];
                else              m_err = 1'b1;
            end
        end
    endtask

    // ctrl behaviour: hold and re-present the op until busy is low.
    task automatic issue(input bit [4:0] op, input bit [5:0] limm, input bit [31:0] a,
                         output int acc_cyc);
        bit acc;
        int n;
        n = 0;
        acc_cyc = -1;
        do begin
            cycle(1'b1, op, limm, a, acc);
            if (!acc && first_busy_opa < 0) first_busy_opa = int'(a);
            n++;
        end while (!acc && n < 200);
        if (acc) begin
            acc_cyc = cyc;
        end else begin
            total++;
            bad++;
            $display("FAIL issue_timeout: op %b still busy after %0d cycles, want accepted", op, n);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) cycle(1'b0, 5'b0, 6'b0, 32'h0, acc);
    endtask

    task automatic wait_phase(input phase_e p, input int budget);
        int n;
        n = 0;
        while (m_phase != p && n < budget) begin
            idle(1);
            n++;
        end
        if (m_phase != p) begin
            total++;
            bad++;
            $display("FAIL wait_phase: phase %0d not reached in %0d cycles", p, budget);
        end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_result"}, result, 0);
        check({pfx, "_result_valid"}, result_valid, 0);
        check({pfx, "_err"}, err, 0);
        check({pfx, "_core_init"}, core_init, 0);
        check({pfx, "_lane_valid"}, lane_valid, 0);
        check({pfx, "_lane"}, {lane_last, lane_words, lane_data}, 0);
    endtask

    task automatic run_t1_seq();
        int ac;
        issue(K_START, 6'd0, 32'd1, ac);
        for (int v = 2; v <= 6; v++) issue(K_MID, 6'd0, 32'(v), ac);
        issue(K_END, 6'd0, 32'd7, ac);
    endtask

    task automatic check_t1_lanes(input string pfx);
        check({pfx, "_lane_count"}, lane_log.size(), 4);
        check({pfx, "_lane0"}, log_at(0), {2'b00, 32'd2, 32'd1});
        check({pfx, "_lane1"}, log_at(1), {2'b00, 32'd4, 32'd3});
        check({pfx, "_lane2"}, log_at(2), {2'b00, 32'd6, 32'd5});
        check({pfx, "_lane3"}, log_at(3), {2'b11, 32'd0, 32'd7});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ac;
        int r;
        bit [4:0] op;

        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;

        // T1: plain absorb, odd word count ends in a one-word last lane
        lane_log.delete();
        run_t1_seq();
        idle(4);
        check_t1_lanes("t1");

        // T2: backpressure for 20 cycles over the same sequence
        lane_log.delete();
        first_busy_opa = -1;
        stall_until = cyc + 21;
        run_t1_seq();
        wait_phase(P_WAIT, 100);
        check("t2_first_busy_opa", first_busy_opa, 6);
        check_t1_lanes("t2");

        // T3: digest readback, all indices plus a wrapped one
        set_pattern(32'hA500_0000);
        dig_at = cyc + 2;
        wait_phase(P_DONE, 20);
        for (int idx = 15; idx >= 0; idx--) begin
            issue(K_STORE, 6'(idx), 32'h0, ac);
            idle(1);
            check("t3_word", s_result, 32'hA500_0000 + 32'(idx));
            check("t3_valid", s_rv, 1);
        end
        issue(K_STORE, 6'h23, 32'h0, ac);
        idle(1);
        check("t3_wrap_word", s_result, 32'hA500_0003);

        // T4: STORE presented while waiting for the digest
        issue(K_START, 6'd0, 32'h11, ac);
        issue(K_END, 6'd0, 32'h22, ac);
        wait_phase(P_WAIT, 50);
        set_pattern(32'hB600_0000);
        dig_at = cyc + 6;
        issue(K_STORE, 6'd3, 32'h0, ac);
        check("t4_accept_cycle", ac, dig_at + 1);
        idle(1);
        check("t4_word", s_result, 32'hB600_0003);
        check("t4_valid", s_rv, 1);

        // T5: protocol error and INIT clear
        issue(K_INIT, 6'd0, 32'h0, ac);
        issue(K_MID, 6'd0, 32'h5, ac);
        idle(1);
        check("t5_err_set", s_err, 1);
        check("t5_no_lane", s_lv, 0);
        issue(K_INIT, 6'd0, 32'h0, ac);
        idle(1);
        check("t5_err_clear", s_err, 0);
        check("t5_core_init", s_ci, 1);
        idle(1);
        check("t5_core_init_drop", s_ci, 0);

        // T6: asynchronous reset in FLUSH with one lane queued
        stall_until = cyc + 1000;
        issue(K_START, 6'd0, 32'h33, ac);
        issue(K_END, 6'd0, 32'h44, ac);
        idle(1);
        check("t6_lane_queued", s_lv, 1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        cust5_valid  = 1'b0;
        digest_valid = 1'b0;
        #1;
        check_zero("t6");
        model_reset();
        stall_until = 0;
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        issue(K_STORE, 6'd0, 32'h0, ac);
        idle(1);
        check("t6_idle_store_valid", s_rv, 1);
        check("t6_idle_store_err", s_err, 1);

        // Randomized traffic against the model
        rand_ready = 1'b1;
        rand_dig   = 1'b1;
        repeat (1500) begin
            r = $urandom_range(0, 99);
            if (r < 15) begin
                idle(1);
            end else begin
                if      (r < 22) op = K_START;
                else if (r < 58) op = K_MID;
                else if (r < 68) op = K_END;
                else if (r < 92) op = K_STORE;
                else             op = K_INIT;
                issue(op, 6'($urandom()), $urandom(), ac);
            end
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
